// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// Multi-ported register file: one write port with byte-lane enables and two
// independent combinational read ports. Optionally register 0 is hard-wired
// to zero. Optionally a read of the register being written in the same cycle
// sees the new data (write-through).
//
// Parameters
//   WIDTH     data width per register, multiple of 8, >= 8
//   DEPTH     number of registers, power of two, >= 2
//   ZERO_REG  1: register 0 reads as zero and ignores writes
//   BYPASS    1: same-cycle read of the write address returns write data
//
// Ports
//   clk         single clock, all state changes on rising edge
//   rst         synchronous active-high reset, clears storage and wr_count
//   en_reg      write enable
//   wr_addr     write register index
//   wr_be       byte-lane write enables, bit i gates bits [8i+7:8i]
//   D_vector    write data
//   rd_addr_a   read port A index
//   Q_vector_a  read port A data, zero latency
//   rd_addr_b   read port B index
//   Q_vector_b  read port B data, zero latency
//   wr_count    committed writes since reset, saturates at 16'hFFFF
// ---------------------------------------------------------------------------
module register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int NBE     = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_reg,
    input  logic [AW-1:0]    wr_addr,
    input  logic [NBE-1:0]   wr_be,
    input  logic [WIDTH-1:0] D_vector,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] Q_vector_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] Q_vector_b,
    output logic [15:0]      wr_count
);

    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam bit HAS_BYP  = (BYPASS != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [15:0]      count_q;

    logic [WIDTH-1:0] lane_mask;
    logic             wr_to_zero;
    logic             wr_commit;
    logic             wr_active;

    // Expand byte enables into a bit mask so merging is a single and/or.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NBE; i++) begin
            lane_mask[8*i +: 8] = {8{wr_be[i]}};
        end
    end

    assign wr_to_zero = HAS_ZERO && (wr_addr == '0);

    // Reset wins over a concurrent write; an all-zero byte enable is a no-op
    // and must not bump the counter.
    assign wr_commit = !rst && en_reg && (|wr_be) && !wr_to_zero;

    // Forwarding is only meaningful while not in reset; under reset the
    // ports show the stored contents until the clearing edge.
    assign wr_active = !rst && en_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            count_q <= '0;
        end else if (wr_commit) begin
            mem[wr_addr] <= (mem[wr_addr] & ~lane_mask) | (D_vector & lane_mask);
            if (count_q != 16'hFFFF) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign wr_count = count_q;

    // Shared read-path logic for both ports: zero register, then optional
    // write-through lane merge, else the stored word.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [AW-1:0]    addr,
        input logic [WIDTH-1:0] stored,
        input logic             fwd_en,
        input logic [AW-1:0]    waddr,
        input logic [WIDTH-1:0] wdata,
        input logic [WIDTH-1:0] mask
    );
        logic [WIDTH-1:0] result;
        result = stored;
        if (HAS_ZERO && (addr == '0)) begin
            result = '0;
        end else if (HAS_BYP && fwd_en && (addr == waddr)) begin
            result = (stored & ~mask) | (wdata & mask);
        end
        return result;
    endfunction

    always_comb begin
        Q_vector_a = read_port(rd_addr_a, mem[rd_addr_a], wr_active,
                               wr_addr, D_vector, lane_mask);
    end

    always_comb begin
        Q_vector_b = read_port(rd_addr_b, mem[rd_addr_b], wr_active,
                               wr_addr, D_vector, lane_mask);
    end

endmodule
